// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several byte requesters share one UART transmitter.
// Holds a packet lock until the owner's last byte completes or the tx_done wait times out.
`timescale 1ns / 1ps
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned PACK_SIZE   = 8,
  parameter int unsigned CLK_PER_BIT = 868
) (
  input  logic                         CLK100MHZ,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*PACK_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_byte_valid,
  output logic [PACK_SIZE-1:0]         tx_byte_data,
  input  logic                         tx_done,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int unsigned TIMEOUT_CYC = 16 * CLK_PER_BIT;
  localparam int unsigned IdxW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

  typedef enum logic [1:0] {StArb, StAccept, StSend, StWaitDone} state_e;

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [IdxW-1:0]       last_owner_q, last_owner_d;
  logic [PACK_SIZE-1:0]  data_q, data_d;
  logic                  last_q, last_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;

  logic                  win_found;
  logic [IdxW-1:0]       win_idx;
  logic [IdxW-1:0]       cand_idx;
  int unsigned           cand;

  // First valid requester strictly after last_owner, wrapping at NUM_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand     = (32'(last_owner_q) + i) % NUM_REQ;
      cand_idx = IdxW'(cand);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    data_d       = data_q;
    last_d       = last_q;
    cnt_d        = '0;
    timeout_d    = 1'b0;
    case (state_q)
      StArb: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          state_d          = StAccept;
        end
      end
      StAccept: begin
        if (req_valid[owner_q]) begin
          data_d  = req_data[32'(owner_q) * PACK_SIZE +: PACK_SIZE];
          last_d  = req_last[owner_q];
          state_d = StSend;
        end
      end
      StSend: state_d = StWaitDone;
      StWaitDone: begin
        cnt_d = cnt_q + 16'd1;
        // tx_done takes priority over an expiry landing in the same cycle.
        if (tx_done) begin
          if (last_q) begin
            last_owner_d = owner_q;
            grant_d      = '0;
            state_d      = StArb;
          end else begin
            state_d = StAccept;
          end
        end else if (cnt_q == TimeoutLast) begin
          timeout_d    = 1'b1;
          last_owner_d = owner_q;
          grant_d      = '0;
          state_d      = StArb;
        end
      end
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q      <= StArb;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= LastIdx;
      data_q       <= '0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      data_q       <= data_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // Strobes are masked while reset is held so nothing handshakes or sends mid-abort.
  assign req_ready     = (state_q == StAccept && !reset) ? grant_q : '0;
  assign tx_byte_valid = (state_q == StSend) && !reset;
  assign busy          = (state_q != StArb) && !reset;
  assign grant         = grant_q;
  assign tx_byte_data  = data_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle vectors plus timeout, collision and reset sequences.
`timescale 1ns / 1ps
module tb_uart_tx_arbiter;

  logic        CLK100MHZ = 1'b0;
  logic        reset     = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_last  = '0;
  logic [3:0]  req_ready;
  logic        tx_byte_valid;
  logic [7:0]  tx_byte_data;
  logic        tx_done   = 1'b0;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter dut (
    .CLK100MHZ    (CLK100MHZ),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_byte_valid(tx_byte_valid),
    .tx_byte_data (tx_byte_data),
    .tx_done      (tx_done),
    .grant        (grant),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        done;
    logic [3:0]  grant;
    logic [3:0]  rdy;
    logic        txv;
    logic [7:0]  txd;
    logic        busy;
    logic        terr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [31:0] data,
                              input logic [3:0] last, input logic done, input logic [3:0] g,
                              input logic [3:0] rdy, input logic txv, input logic [7:0] txd,
                              input logic bsy, input logic terr);
    vec_t v;
    v.rst = rst; v.valid = valid; v.data = data; v.last = last; v.done = done;
    v.grant = g; v.rdy = rdy; v.txv = txv; v.txd = txd; v.busy = bsy; v.terr = terr;
    return v;
  endfunction

  task automatic chk(input string tag, input string f, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", tag, f, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge, sample outputs on the falling edge.
  task automatic apply(input vec_t v, input string tag, input bit do_chk);
    @(posedge CLK100MHZ);
    #1;
    reset     = v.rst;
    req_valid = v.valid;
    req_data  = v.data;
    req_last  = v.last;
    tx_done   = v.done;
    @(negedge CLK100MHZ);
    if (do_chk) begin
      chk(tag, "grant", 32'(grant), 32'(v.grant));
      chk(tag, "req_ready", 32'(req_ready), 32'(v.rdy));
      chk(tag, "tx_byte_valid", 32'(tx_byte_valid), 32'(v.txv));
      chk(tag, "tx_byte_data", 32'(tx_byte_data), 32'(v.txd));
      chk(tag, "busy", 32'(busy), 32'(v.busy));
      chk(tag, "timeout_err", 32'(timeout_err), 32'(v.terr));
    end
  endtask

  // Idle in WAIT_DONE without tx_done; counts cycles that show anything but a quiet wait.
  task automatic wait_cycles(input int n, input logic [3:0] valid, input logic [3:0] g,
                             input logic [7:0] d, output int bad);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge CLK100MHZ);
      #1;
      reset     = 1'b0;
      req_valid = valid;
      tx_done   = 1'b0;
      @(negedge CLK100MHZ);
      if (tx_byte_valid !== 1'b0 || timeout_err !== 1'b0 || grant !== g || busy !== 1'b1 ||
          req_ready !== 4'b0000 || tx_byte_data !== d) bad++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] DF = 32'hA3A2_A1A0;

  initial begin
    int bad;
    repeat (2) @(posedge CLK100MHZ);

    // Reset state and single byte from requester 2.
    vq.push_back(mk(1, 4'b0000, 32'h0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 4'b0100, 32'h0041_0000, 4'b0100, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 4'b0100, 32'h0041_0000, 4'b0100, 0, 4'b0100, 4'b0100, 0, 8'h00, 1, 0));
    vq.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0100, 4'b0000, 1, 8'h41, 1, 0));
    vq.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0100, 4'b0000, 0, 8'h41, 1, 0));
    vq.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 1, 4'b0100, 4'b0000, 0, 8'h41, 1, 0));
    vq.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h41, 0, 0));
    vq.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h41, 0, 0));
    vq.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h41, 0, 0));
    // Fairness after reset: 0,1,2,3,0.
    vq.push_back(mk(1, 4'b1111, DF, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h41, 0, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 0, 4'b0001, 4'b0001, 0, 8'h00, 1, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 0, 4'b0001, 4'b0000, 1, 8'hA0, 1, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 0, 4'b0001, 4'b0000, 0, 8'hA0, 1, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 1, 4'b0001, 4'b0000, 0, 8'hA0, 1, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'hA0, 0, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 0, 4'b0010, 4'b0010, 0, 8'hA0, 1, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 0, 4'b0010, 4'b0000, 1, 8'hA1, 1, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 1, 4'b0010, 4'b0000, 0, 8'hA1, 1, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'hA1, 0, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 0, 4'b0100, 4'b0100, 0, 8'hA1, 1, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 0, 4'b0100, 4'b0000, 1, 8'hA2, 1, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 1, 4'b0100, 4'b0000, 0, 8'hA2, 1, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'hA2, 0, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 0, 4'b1000, 4'b1000, 0, 8'hA2, 1, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 0, 4'b1000, 4'b0000, 1, 8'hA3, 1, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 1, 4'b1000, 4'b0000, 0, 8'hA3, 1, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'hA3, 0, 0));
    vq.push_back(mk(0, 4'b1111, DF, 4'b1111, 0, 4'b0001, 4'b0001, 0, 8'hA3, 1, 0));
    vq.push_back(mk(0, 4'b0000, DF, 4'b1111, 0, 4'b0001, 4'b0000, 1, 8'hA0, 1, 0));
    vq.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 1, 4'b0001, 4'b0000, 0, 8'hA0, 1, 0));
    // Packet lock: requester 1 sends 10,11,12 while 0 waits and 2 arrives mid-packet.
    vq.push_back(mk(0, 4'b0011, 32'h0077_1055, 4'b0001, 0, 4'b0000, 4'b0000, 0, 8'hA0, 0, 0));
    vq.push_back(mk(0, 4'b0011, 32'h0077_1055, 4'b0001, 0, 4'b0010, 4'b0010, 0, 8'hA0, 1, 0));
    vq.push_back(mk(0, 4'b0011, 32'h0077_1155, 4'b0001, 0, 4'b0010, 4'b0000, 1, 8'h10, 1, 0));
    vq.push_back(mk(0, 4'b0111, 32'h0077_1155, 4'b0101, 0, 4'b0010, 4'b0000, 0, 8'h10, 1, 0));
    vq.push_back(mk(0, 4'b0111, 32'h0077_1155, 4'b0101, 1, 4'b0010, 4'b0000, 0, 8'h10, 1, 0));
    vq.push_back(mk(0, 4'b0101, 32'h0077_1155, 4'b0101, 0, 4'b0010, 4'b0010, 0, 8'h10, 1, 0));
    vq.push_back(mk(0, 4'b0111, 32'h0077_1155, 4'b0101, 0, 4'b0010, 4'b0010, 0, 8'h10, 1, 0));
    vq.push_back(mk(0, 4'b0111, 32'h0077_1255, 4'b0111, 0, 4'b0010, 4'b0000, 1, 8'h11, 1, 0));
    vq.push_back(mk(0, 4'b0111, 32'h0077_1255, 4'b0111, 1, 4'b0010, 4'b0000, 0, 8'h11, 1, 0));
    vq.push_back(mk(0, 4'b0111, 32'h0077_1255, 4'b0111, 0, 4'b0010, 4'b0010, 0, 8'h11, 1, 0));
    vq.push_back(mk(0, 4'b0101, 32'h0077_1255, 4'b0101, 0, 4'b0010, 4'b0000, 1, 8'h12, 1, 0));
    vq.push_back(mk(0, 4'b0101, 32'h0077_1255, 4'b0101, 1, 4'b0010, 4'b0000, 0, 8'h12, 1, 0));
    vq.push_back(mk(0, 4'b0101, 32'h0077_1255, 4'b0101, 0, 4'b0000, 4'b0000, 0, 8'h12, 0, 0));
    vq.push_back(mk(0, 4'b0101, 32'h0077_1255, 4'b0101, 0, 4'b0100, 4'b0100, 0, 8'h12, 1, 0));
    vq.push_back(mk(0, 4'b0001, 32'h0077_1255, 4'b0001, 0, 4'b0100, 4'b0000, 1, 8'h77, 1, 0));
    vq.push_back(mk(0, 4'b0001, 32'h0077_1255, 4'b0001, 1, 4'b0100, 4'b0000, 0, 8'h77, 1, 0));
    vq.push_back(mk(0, 4'b0001, 32'h0077_1255, 4'b0001, 0, 4'b0000, 4'b0000, 0, 8'h77, 0, 0));
    vq.push_back(mk(0, 4'b0001, 32'h0077_1255, 4'b0001, 0, 4'b0001, 4'b0001, 0, 8'h77, 1, 0));
    vq.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0001, 4'b0000, 1, 8'h55, 1, 0));
    vq.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 1, 4'b0001, 4'b0000, 0, 8'h55, 1, 0));
    vq.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h55, 0, 0));

    foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i), 1'b1);

    // Timeout: requester 1 never gets tx_done; pulse 13888 cycles after WAIT_DONE entry.
    apply(mk(0, 4'b1010, 32'h3C00_5A00, 4'b1010, 0, 4'b0000, 4'b0000, 0, 8'h55, 0, 0), "to0", 1);
    apply(mk(0, 4'b1010, 32'h3C00_5A00, 4'b1010, 0, 4'b0010, 4'b0010, 0, 8'h55, 1, 0), "to1", 1);
    apply(mk(0, 4'b1000, 32'h3C00_5A00, 4'b1010, 0, 4'b0010, 4'b0000, 1, 8'h5A, 1, 0), "to2", 1);
    wait_cycles(13888, 4'b1000, 4'b0010, 8'h5A, bad);
    chk("to_wait", "bad_cycles", 32'(bad), 32'd0);
    apply(mk(0, 4'b1000, 32'h3C00_5A00, 4'b1010, 0, 4'b0000, 4'b0000, 0, 8'h5A, 0, 1), "to3", 1);
    apply(mk(0, 4'b1000, 32'h3C00_5A00, 4'b1010, 0, 4'b1000, 4'b1000, 0, 8'h5A, 1, 0), "to4", 1);
    apply(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b1000, 4'b0000, 1, 8'h3C, 1, 0), "to5", 1);
    apply(mk(0, 4'b0000, 32'h0, 4'b0000, 1, 4'b1000, 4'b0000, 0, 8'h3C, 1, 0), "to6", 1);
    apply(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h3C, 0, 0), "to7", 1);

    // tx_done on the expiry cycle wins; a later stray tx_done in ARB does nothing.
    apply(mk(0, 4'b0001, 32'h0000_00C5, 4'b0001, 0, 4'b0000, 4'b0000, 0, 8'h3C, 0, 0), "co0", 1);
    apply(mk(0, 4'b0001, 32'h0000_00C5, 4'b0001, 0, 4'b0001, 4'b0001, 0, 8'h3C, 1, 0), "co1", 1);
    apply(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0001, 4'b0000, 1, 8'hC5, 1, 0), "co2", 1);
    wait_cycles(13887, 4'b0000, 4'b0001, 8'hC5, bad);
    chk("co_wait", "bad_cycles", 32'(bad), 32'd0);
    apply(mk(0, 4'b0000, 32'h0, 4'b0000, 1, 4'b0001, 4'b0000, 0, 8'hC5, 1, 0), "co3", 1);
    apply(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'hC5, 0, 0), "co4", 1);
    apply(mk(0, 4'b0000, 32'h0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'hC5, 0, 0), "co5", 1);
    apply(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'hC5, 0, 0), "co6", 1);

    // Reset while waiting for tx_done, then a late tx_done, then a fresh request.
    apply(mk(0, 4'b0100, 32'h0066_0000, 4'b0100, 0, 4'b0000, 4'b0000, 0, 8'hC5, 0, 0), "rs0", 1);
    apply(mk(0, 4'b0100, 32'h0066_0000, 4'b0100, 0, 4'b0100, 4'b0100, 0, 8'hC5, 1, 0), "rs1", 1);
    apply(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0100, 4'b0000, 1, 8'h66, 1, 0), "rs2", 1);
    apply(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0100, 4'b0000, 0, 8'h66, 1, 0), "rs3", 1);
    apply(mk(1, 4'b0000, 32'h0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0), "rsx", 0);
    apply(mk(0, 4'b0000, 32'h0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h00, 0, 0), "rs4", 1);
    apply(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0), "rs5", 1);
    apply(mk(0, 4'b0010, 32'h0000_9900, 4'b0010, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0), "rs6", 1);
    apply(mk(0, 4'b0010, 32'h0000_9900, 4'b0010, 0, 4'b0010, 4'b0010, 0, 8'h00, 1, 0), "rs7", 1);
    apply(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0010, 4'b0000, 1, 8'h99, 1, 0), "rs8", 1);
    apply(mk(0, 4'b0000, 32'h0, 4'b0000, 1, 4'b0010, 4'b0000, 0, 8'h99, 1, 0), "rs9", 1);
    apply(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h99, 0, 0), "rs10", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
